token_streamer: RTL and testbench

- Downstream stage of the grouper. After grouping completes, it reads the grouped token words out of the grouper's output SRAM through a dedicated read port.
- Tokens are emitted in address order on a valid/ready stream toward the next stage (embedding/tensor core feed).
- A small prefetch FIFO hides the 1-cycle SRAM read latency, so a continuously ready consumer sees one token per cycle.

---
 rtl/token_streamer.sv | 91 +++++++++
 tb/tb_token_streamer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/token_streamer.sv
// token_streamer: streams grouped tokens from the output SRAM over valid/ready with a prefetch FIFO.
// Optional TOKEN_STREAMER_STATS_EN adds the stall_cycles counter port.
module token_streamer #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   count,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic [DATA_WIDTH-1:0] tok_data,
  output logic                  tok_valid,
  input  logic                  tok_ready,
  output logic                  tok_last,
  output logic                  busy,
  output logic                  done
`ifdef TOKEN_STREAMER_STATS_EN
  ,
  output logic [15:0]           stall_cycles
`endif
);
  localparam int AW1 = ADDR_WIDTH + 1;
  localparam int CW = $clog2(FIFO_DEPTH);
  localparam int CW1 = CW + 1;
  localparam logic [ADDR_WIDTH:0] MAX_LEN = AW1'(1) << ADDR_WIDTH;
  localparam logic [CW:0] DEPTH = CW1'(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FINISH} state_t;
  state_t state, state_n;
  logic [ADDR_WIDTH:0] len, len_in, rd_idx, emit_idx;
  logic [CW:0] fifo_cnt;
  logic [CW-1:0] wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] fifo [FIFO_DEPTH];
  logic inflight, pop, accept;
  assign len_in = count > MAX_LEN ? MAX_LEN : count;
  assign accept = state == IDLE && start;
  // in-flight read reserves its slot so the FIFO can never overflow
  assign mem_re = state == FETCH && (fifo_cnt + CW1'(inflight)) < DEPTH;
  assign mem_addr = rd_idx[ADDR_WIDTH-1:0];
  assign tok_valid = fifo_cnt != '0;
  assign tok_data = tok_valid ? fifo[rd_ptr] : '0;
  assign tok_last = tok_valid && emit_idx == len - AW1'(1);
  assign pop = tok_valid && tok_ready;
  assign busy = state == FETCH || state == DRAIN;
  assign done = state == FINISH;
  always_comb begin
    state_n = state;
    if (accept) state_n = len_in == '0 ? FINISH : FETCH;
    else if (state == FETCH && mem_re && rd_idx + AW1'(1) == len) state_n = DRAIN;
    else if (state == DRAIN && pop && tok_last) state_n = FINISH;
    else if (state == FINISH) state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      len <= '0;
      rd_idx <= '0;
      emit_idx <= '0;
      inflight <= 1'b0;
      fifo_cnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state <= state_n;
      inflight <= mem_re;
      if (accept) begin
        len <= len_in;
        rd_idx <= '0;
        emit_idx <= '0;
      end else begin
        if (mem_re) rd_idx <= rd_idx + AW1'(1);
        if (pop) emit_idx <= emit_idx + AW1'(1);
      end
      if (inflight) wr_ptr <= wr_ptr + CW'(1);
      if (pop) rd_ptr <= rd_ptr + CW'(1);
      fifo_cnt <= fifo_cnt + CW1'(inflight) - CW1'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (inflight) fifo[wr_ptr] <= mem_dout;
  end
`ifdef TOKEN_STREAMER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || accept) stall_cycles <= '0;
    else if (tok_valid && !tok_ready && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
  end
`endif
endmodule

// File: tb/tb_token_streamer.sv
// tb_token_streamer: table-driven stream checks plus reset and stats sequences for token_streamer.
module tb_token_streamer;
  logic clk = 0, rst = 1, start = 0, tok_ready = 0;
  logic [4:0] count = '0;
  logic mem_re, tok_valid, tok_last, busy, done;
  logic [3:0] mem_addr;
  logic [7:0] mem_dout = '0, tok_data;
  logic [7:0] sram [16];
  int total = 0, bad = 0;
`ifdef TOKEN_STREAMER_STATS_EN
  logic [15:0] stall_cycles;
`endif
  token_streamer dut (
    .clk(clk), .rst(rst), .start(start), .count(count),
    .mem_re(mem_re), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .tok_data(tok_data), .tok_valid(tok_valid), .tok_ready(tok_ready),
    .tok_last(tok_last), .busy(busy), .done(done)
`ifdef TOKEN_STREAMER_STATS_EN
    , .stall_cycles(stall_cycles)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (mem_re) mem_dout <= sram[mem_addr];
  typedef struct {
    int cnt;
    logic [15:0] pat;
    int n;
    bit mode;
  } vec_t;
  vec_t v[6];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic load_mem(input bit mode);
    for (int i = 0; i < 16; i++) sram[i] = mode ? 8'(i) : 8'(8'h11 * (i + 1));
  endtask
  task automatic run_stream(input int cnt, input logic [15:0] pat, input int n);
    int got = 0, issued = 0, first = -1, hs = -1, dcyc = -1;
    logic prev_stall = 0, prev_last = 0;
    logic [7:0] prev_data = '0;
    @(negedge clk);
    count = 5'(cnt);
    start = 1;
    @(negedge clk);
    start = 0;
    count = '0;
    chk("busy_after_start", busy, n != 0);
    for (int cyc = 0; cyc < 200; cyc++) begin
      tok_ready = pat[cyc % 16];
      #1;
      if (done) begin
        dcyc = cyc;
        break;
      end
      if (tok_valid && first < 0) first = cyc;
      if (mem_re) begin
        chk("mem_addr", mem_addr, issued % 16);
        issued++;
      end
      if (prev_stall) chk("hold", {tok_valid, tok_data, tok_last}, {1'b1, prev_data, prev_last});
      if (tok_valid && tok_ready) begin
        chk("tok_data", tok_data, sram[got]);
        chk("tok_last", tok_last, got == n - 1);
        got++;
        if (got == n) hs = cyc;
      end
      if (issued - got > 4) chk("occupancy", issued - got, 4);
      prev_stall = tok_valid && !tok_ready;
      prev_data = tok_data;
      prev_last = tok_last;
      @(negedge clk);
    end
    chk("ntok", got, n);
    chk("nreads", issued, n);
    chk("first_valid", first, n == 0 ? -1 : 2);
    chk("done_cycle", dcyc, n == 0 ? 0 : hs + 1);
    @(negedge clk);
    chk("done_pulse", {done, busy}, 2'b00);
  endtask
  initial begin
    v[0] = '{5, 16'hFFFF, 5, 1'b0};
    v[1] = '{6, 16'h9249, 6, 1'b0};
    v[2] = '{0, 16'hFFFF, 0, 1'b0};
    v[3] = '{16, 16'hFFFF, 16, 1'b1};
    v[4] = '{31, 16'hAAAA, 16, 1'b1};
    v[5] = '{1, 16'hFF00, 1, 1'b0};
    load_mem(0);
    repeat (2) @(negedge clk);
    chk("reset_outs", {tok_valid, tok_last, mem_re, busy, done, tok_data, mem_addr}, '0);
    rst = 0;
    foreach (v[i]) begin
      load_mem(v[i].mode);
      run_stream(v[i].cnt, v[i].pat, v[i].n);
    end
    // reset after three accepted tokens, with a stray start mid-stream
    load_mem(0);
    begin
      int got = 0;
      @(negedge clk);
      count = 5'd5;
      start = 1;
      tok_ready = 1;
      @(negedge clk);
      start = 0;
      for (int cyc = 0; cyc < 50 && got < 3; cyc++) begin
        #1;
        start = cyc == 2;
        count = 5'd1;
        if (tok_valid && tok_ready) begin
          chk("rst_seq_data", tok_data, sram[got]);
          chk("rst_seq_last", tok_last, 0);
          got++;
        end
        @(negedge clk);
      end
      start = 0;
      chk("rst_seq_ntok", got, 3);
      rst = 1;
      @(negedge clk);
      chk("midrst_outs", {tok_valid, tok_last, mem_re, busy, done, tok_data, mem_addr}, '0);
      rst = 0;
      for (int cyc = 0; cyc < 4; cyc++) begin
        @(negedge clk);
        chk("no_done_after_rst", {done, tok_valid}, 2'b00);
      end
    end
    run_stream(2, 16'hFFFF, 2);
`ifdef TOKEN_STREAMER_STATS_EN
    run_stream(4, 16'hFFE3, 4);
    chk("stall_cycles", stall_cycles, 3);
    run_stream(0, 16'hFFFF, 0);
    chk("stall_clear_start", stall_cycles, 0);
    run_stream(3, 16'hFFF3, 3);
    chk("stall_cycles2", stall_cycles, 2);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("stall_clear_rst", stall_cycles, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
